cursor_ctrl: RTL and testbench
==============================

Name: cursor_ctrl

Overview:
Keyboard-to-game cursor controller. It sits between Keyboard and Play: it consumes key_event and drives the cursor_x, cursor_y and is_pressed inputs of Play. It turns decoded PS/2 make/break events into cursor moves on the board, with internal hold-to-repeat, and a single-shot select pulse. It also emits cursor_moved, which drives the move sound.

Parameters:
BOARD_W, 8, board columns; cursor_x range 0..BOARD_W-1
BOARD_H, 8, board rows; cursor_y range 0..BOARD_H-1
REPEAT_DELAY, 25000000, clk cycles from the initial move to the first auto-repeat move
REPEAT_PERIOD, 5000000, clk cycles between subsequent auto-repeat moves
CNT_W, 25, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD)-1

Ports:
clk  input  1  system clock (same domain as Keyboard and Play)
rstn  input  1  asynchronous active-low reset
key_event  input  11  [10]=event strobe (one cycle), [9]=break, [8]=extended (E0), [7:0]=scan code
cursor_x  output  4  cursor column
cursor_y  output  4  cursor row
is_pressed  output  1  one-cycle select pulse to Play
cursor_moved  output  1  one-cycle pulse whenever cursor_x/cursor_y changes

Behaviour:
- Reset (async, rstn=0): cursor_x=0, cursor_y=0, is_pressed=0, cursor_moved=0, FSM=IDLE, held key cleared, select_held=0, counter=0.
- An event is consumed only on a cycle with key_event[10]=1. Other bits are ignored when the strobe is 0.
- Latency: all outputs are registered. The effect appears on the cycle after the strobe.
- Key map:
  - Up: E0 75 or 1D (W).
  - Down: E0 72 or 1B (S).
  - Left: E0 6B or 1C (A).
  - Right: E0 74 or 23 (D).
  - Select: 5A (Enter, either extended value) or 29 (Space).
  - Arrows require extended=1. Letters and Space require extended=0.
  - All other codes are ignored.
- Move arithmetic: Up decrements y, Down increments y, Left decrements x, Right increments x.
  - Default: saturate at 0 and BOARD_W-1 / BOARD_H-1.
  - A saturated (no-change) move does not assert cursor_moved.
- Direction FSM:
  - IDLE: direction make -> move once, latch held key, counter=REPEAT_DELAY-1, go to HELD.
  - HELD, counter decrement: counter decrements every cycle. At 0 -> move by held key, counter=REPEAT_PERIOD-1.
  - HELD, same-key make (PS/2 typematic): ignored; neither counter nor position changes.
  - HELD, different direction make: move by the new key, latch it as held, counter=REPEAT_DELAY-1. Last key wins.
  - HELD, break of held key: go to IDLE, no move.
  - HELD, break of any non-held key: ignored.
- Simultaneous events: a new-key make and counter expiry on the same cycle -> only the new key's move occurs and the counter reloads REPEAT_DELAY-1. Never more than one move per cycle.
- Select:
  - Select make with select_held=0 -> is_pressed=1 for one cycle, select_held=1.
  - Further select makes while held produce no pulse.
  - Select break clears select_held.
  - Select is independent of the direction FSM; a select event does not disturb the counter.
- cursor_moved and is_pressed are high for exactly one cycle per qualifying event.
- Reset mid-hold or mid-pulse: immediate return to reset values. The next make after rstn rises is handled from IDLE.

Optional Feature:
CURSOR_WRAP_EN
- Defined: moves past an edge wrap to the opposite edge (x=BOARD_W-1 + Right -> 0; y=0 + Up -> BOARD_H-1), and cursor_moved asserts on every wrap.
- Undefined: saturation as in Behaviour.

Test Plan:
Bench parameters for all scenarios: REPEAT_DELAY=10, REPEAT_PERIOD=4.
1. Reset, then Right make {1,0,1,0x74} -> next cycle cursor_x=1, cursor_moved pulse. Break {1,1,1,0x74} after 5 cycles -> no further moves, FSM IDLE.
2. Hold D (0x23 make, no break) for 30 cycles -> moves at cycles 1, 11, 15, 19, 23, 27; cursor_x=6 at cycle 28. Injected typematic 0x23 makes change nothing.
3. Without the macro: at x=7, Right make -> x stays 7, no cursor_moved. With CURSOR_WRAP_EN: x=0, cursor_moved=1. At y=0, Up (0x1D) -> y=0 (saturate) or 7 (wrap).
4. Space make 0x29 three times, then break, then make -> exactly two is_pressed pulses (first make and the make after the break), each 1 cycle wide.
5. Hold Down, then Left make on the same cycle the counter expires -> only x decrements; y unchanged that cycle; next Left move 10 cycles later.
6. Hold Right for 12 cycles, assert rstn=0 for 2 cycles -> outputs 0 immediately. After release, with no new events, no moves for 50 cycles.

Source files
------------

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: keyboard-to-game cursor controller.
// Turns decoded PS/2 make/break events into cursor moves on a BOARD_W x BOARD_H
// board, with hold-to-repeat on the direction keys and a single-shot select
// pulse. All outputs are registered; an event's effect shows on the cycle
// after its strobe.
//
// Optional build macro: CURSOR_WRAP_EN
//   defined   -> moves past an edge wrap to the opposite edge
//   undefined -> moves saturate at the board edges
//
// Handshake: key_event[10] is a one-cycle strobe with no back-pressure; the
// other key_event bits are only looked at on a strobe cycle, and every strobed
// event is consumed on that cycle.
//
// Debug: o_fsm_state exposes the direction FSM (0 = IDLE, 1 = HELD).
module cursor_ctrl #(
  parameter int BOARD_W       = 8,
  parameter int BOARD_H       = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [10:0] key_event,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        is_pressed,
  output logic        cursor_moved,
  output logic        o_fsm_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [3:0]       X_MAX   = 4'(BOARD_W - 1);
  localparam logic [3:0]       Y_MAX   = 4'(BOARD_H - 1);
  localparam logic [CNT_W-1:0] CNT_DLY = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_PER = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Event fields
  logic       w_strobe;
  logic       w_break;
  logic       w_ext;
  logic [7:0] w_code;

  // Decoded key
  logic       w_dir_valid;
  dir_t       w_dir;
  logic       w_sel;
  logic       w_make_dir;
  logic       w_break_held;

  // Registered state
  state_t           r_state;
  dir_t             r_held_dir;
  logic [8:0]       r_held_key;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic             r_sel_held;
  logic             r_pressed;
  logic             r_moved;

  // Next-state values
  state_t           w_state_nxt;
  dir_t             w_held_dir_nxt;
  logic [8:0]       w_held_key_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_move_req;
  dir_t             w_move_dir;
  logic [3:0]       w_x_nxt;
  logic [3:0]       w_y_nxt;
  logic             w_moved_nxt;

  assign w_strobe = key_event[10];
  assign w_break  = key_event[9];
  assign w_ext    = key_event[8];
  assign w_code   = key_event[7:0];

  // Key map: arrows need the E0 prefix, WASD and Space must not have it;
  // Enter is accepted with either prefix value.
  always_comb begin
    w_dir_valid = 1'b0;
    w_dir       = DIR_UP;
    if (w_ext) begin
      case (w_code)
        8'h75:   begin w_dir_valid = 1'b1; w_dir = DIR_UP;    end
        8'h72:   begin w_dir_valid = 1'b1; w_dir = DIR_DOWN;  end
        8'h6B:   begin w_dir_valid = 1'b1; w_dir = DIR_LEFT;  end
        8'h74:   begin w_dir_valid = 1'b1; w_dir = DIR_RIGHT; end
        default: begin w_dir_valid = 1'b0; w_dir = DIR_UP;    end
      endcase
    end else begin
      case (w_code)
        8'h1D:   begin w_dir_valid = 1'b1; w_dir = DIR_UP;    end
        8'h1B:   begin w_dir_valid = 1'b1; w_dir = DIR_DOWN;  end
        8'h1C:   begin w_dir_valid = 1'b1; w_dir = DIR_LEFT;  end
        8'h23:   begin w_dir_valid = 1'b1; w_dir = DIR_RIGHT; end
        default: begin w_dir_valid = 1'b0; w_dir = DIR_UP;    end
      endcase
    end
  end

  assign w_sel        = w_strobe && ((w_code == 8'h5A) || (!w_ext && w_code == 8'h29));
  assign w_make_dir   = w_strobe && !w_break && w_dir_valid;
  // Release is matched on the exact key held, so releasing a different key
  // that happens to share the direction does not stop the repeat.
  assign w_break_held = w_strobe && w_break && ({w_ext, w_code} == r_held_key);

  // Direction FSM next state: a new-direction make beats counter expiry, so
  // at most one move is requested per cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_held_dir_nxt = r_held_dir;
    w_held_key_nxt = r_held_key;
    w_cnt_nxt      = r_cnt;
    w_move_req     = 1'b0;
    w_move_dir     = r_held_dir;
    case (r_state)
      ST_IDLE: begin
        if (w_make_dir) begin
          w_move_req     = 1'b1;
          w_move_dir     = w_dir;
          w_held_dir_nxt = w_dir;
          w_held_key_nxt = {w_ext, w_code};
          w_cnt_nxt      = CNT_DLY;
          w_state_nxt    = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_break_held) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_make_dir && (w_dir != r_held_dir)) begin
          w_move_req     = 1'b1;
          w_move_dir     = w_dir;
          w_held_dir_nxt = w_dir;
          w_held_key_nxt = {w_ext, w_code};
          w_cnt_nxt      = CNT_DLY;
        end else if (r_cnt == '0) begin
          w_move_req = 1'b1;
          w_move_dir = r_held_dir;
          w_cnt_nxt  = CNT_PER;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Move arithmetic: edge behaviour is saturate or wrap depending on build.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_move_req) begin
      case (w_move_dir)
        DIR_UP: begin
          if (r_y == 4'd0) begin
`ifdef CURSOR_WRAP_EN
            w_y_nxt = Y_MAX;
`else
            w_y_nxt = r_y;
`endif
          end else begin
            w_y_nxt = r_y - 4'd1;
          end
        end
        DIR_DOWN: begin
          if (r_y >= Y_MAX) begin
`ifdef CURSOR_WRAP_EN
            w_y_nxt = 4'd0;
`else
            w_y_nxt = r_y;
`endif
          end else begin
            w_y_nxt = r_y + 4'd1;
          end
        end
        DIR_LEFT: begin
          if (r_x == 4'd0) begin
`ifdef CURSOR_WRAP_EN
            w_x_nxt = X_MAX;
`else
            w_x_nxt = r_x;
`endif
          end else begin
            w_x_nxt = r_x - 4'd1;
          end
        end
        default: begin
          if (r_x >= X_MAX) begin
`ifdef CURSOR_WRAP_EN
            w_x_nxt = 4'd0;
`else
            w_x_nxt = r_x;
`endif
          end else begin
            w_x_nxt = r_x + 4'd1;
          end
        end
      endcase
    end
  end

  // A saturated move leaves the position alone and so raises no move pulse.
  assign w_moved_nxt = (w_x_nxt != r_x) || (w_y_nxt != r_y);

  // Direction FSM, repeat counter and cursor position registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_held_dir <= DIR_UP;
      r_held_key <= '0;
      r_cnt      <= '0;
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_moved    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_held_dir <= w_held_dir_nxt;
      r_held_key <= w_held_key_nxt;
      r_cnt      <= w_cnt_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_moved    <= w_moved_nxt;
    end
  end

  // Select: one pulse per press; typematic repeats are swallowed until release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel_held <= 1'b0;
      r_pressed  <= 1'b0;
    end else begin
      r_pressed <= 1'b0;
      if (w_sel) begin
        if (w_break) begin
          r_sel_held <= 1'b0;
        end else if (!r_sel_held) begin
          r_sel_held <= 1'b1;
          r_pressed  <= 1'b1;
        end
      end
    end
  end

  assign cursor_x     = r_x;
  assign cursor_y     = r_y;
  assign is_pressed   = r_pressed;
  assign cursor_moved = r_moved;
  assign o_fsm_state  = r_state;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed testbench for cursor_ctrl with short repeat timing
// (REPEAT_DELAY=10, REPEAT_PERIOD=4). Expected values are hand-computed.
module tb_cursor_ctrl;

  logic        clk;
  logic        rstn;
  logic [10:0] key_event;
  logic [3:0]  cursor_x;
  logic [3:0]  cursor_y;
  logic        is_pressed;
  logic        cursor_moved;
  logic        o_fsm_state;

  int n_checks;
  int n_fail;

  cursor_ctrl #(
    .BOARD_W      (8),
    .BOARD_H      (8),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_event   (key_event),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .is_pressed  (is_pressed),
    .cursor_moved(cursor_moved),
    .o_fsm_state (o_fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input logic brk, input logic ext, input logic [7:0] code);
    return {1'b1, brk, ext, code};
  endfunction

  // Advance one clock; outputs are looked at 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one event; on return the outputs show its effect.
  task automatic send(input logic [10:0] e);
    key_event = e;
    tick();
    key_event = '0;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    key_event = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    key_event = '0;
    tick();
    tick();
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL reset_x got %0d exp 0", cursor_x); end
    n_checks++; if (cursor_y !== 4'd0) begin n_fail++; $display("FAIL reset_y got %0d exp 0", cursor_y); end
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed got %b exp 0", is_pressed); end
    n_checks++; if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved got %b exp 0", cursor_moved); end
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL reset_state got %b exp 0", o_fsm_state); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_make_break();
    int moves;
    send(ev(1'b0, 1'b1, 8'h74));
    n_checks++; if (cursor_x !== 4'd1) begin n_fail++; $display("FAIL mb_x got %0d exp 1", cursor_x); end
    n_checks++; if (cursor_moved !== 1'b1) begin n_fail++; $display("FAIL mb_moved got %b exp 1", cursor_moved); end
    n_checks++; if (o_fsm_state !== 1'b1) begin n_fail++; $display("FAIL mb_held got %b exp 1", o_fsm_state); end
    tick();
    n_checks++; if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL mb_pulse_width got %b exp 0", cursor_moved); end
    tick(); tick(); tick();
    send(ev(1'b1, 1'b1, 8'h74));
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL mb_idle got %b exp 0", o_fsm_state); end
    moves = 0;
    for (int i = 0; i < 20; i++) begin
      if (cursor_moved) moves++;
      tick();
    end
    n_checks++; if (moves !== 0) begin n_fail++; $display("FAIL mb_no_repeat got %0d moves exp 0", moves); end
    n_checks++; if (cursor_x !== 4'd1) begin n_fail++; $display("FAIL mb_x_final got %0d exp 1", cursor_x); end
  endtask

  task automatic test_hold_repeat();
    logic exp_m;
    do_reset();
    send(ev(1'b0, 1'b0, 8'h23));
    // Now at cycle 1 after the make; typematic makes injected at 5 and 14.
    for (int c = 1; c <= 30; c++) begin
      exp_m = (c == 1) || (c == 11) || (c == 15) || (c == 19) || (c == 23) || (c == 27);
      n_checks++;
      if (cursor_moved !== exp_m) begin
        n_fail++; $display("FAIL hold_moved cycle %0d got %b exp %b", c, cursor_moved, exp_m);
      end
      if (c == 28) begin
        n_checks++; if (cursor_x !== 4'd6) begin n_fail++; $display("FAIL hold_x28 got %0d exp 6", cursor_x); end
      end
      key_event = ((c == 5) || (c == 14)) ? ev(1'b0, 1'b0, 8'h23) : 11'd0;
      tick();
    end
    key_event = '0;
    send(ev(1'b1, 1'b0, 8'h23));
  endtask

  task automatic test_edges();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(ev(1'b0, 1'b1, 8'h74));
      send(ev(1'b1, 1'b1, 8'h74));
    end
    n_checks++; if (cursor_x !== 4'd7) begin n_fail++; $display("FAIL edge_x_setup got %0d exp 7", cursor_x); end
    send(ev(1'b0, 1'b1, 8'h74));
`ifdef CURSOR_WRAP_EN
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL edge_right_x got %0d exp 0", cursor_x); end
    n_checks++; if (cursor_moved !== 1'b1) begin n_fail++; $display("FAIL edge_right_moved got %b exp 1", cursor_moved); end
`else
    n_checks++; if (cursor_x !== 4'd7) begin n_fail++; $display("FAIL edge_right_x got %0d exp 7", cursor_x); end
    n_checks++; if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL edge_right_moved got %b exp 0", cursor_moved); end
`endif
    send(ev(1'b1, 1'b1, 8'h74));
    send(ev(1'b0, 1'b0, 8'h1D));
`ifdef CURSOR_WRAP_EN
    n_checks++; if (cursor_y !== 4'd7) begin n_fail++; $display("FAIL edge_up_y got %0d exp 7", cursor_y); end
    n_checks++; if (cursor_moved !== 1'b1) begin n_fail++; $display("FAIL edge_up_moved got %b exp 1", cursor_moved); end
`else
    n_checks++; if (cursor_y !== 4'd0) begin n_fail++; $display("FAIL edge_up_y got %0d exp 0", cursor_y); end
    n_checks++; if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL edge_up_moved got %b exp 0", cursor_moved); end
`endif
    send(ev(1'b1, 1'b0, 8'h1D));
    // Wrong prefix: extended W and non-extended Up arrow are not keys.
    send(ev(1'b0, 1'b1, 8'h1D));
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL edge_ext_w_state got %b exp 0", o_fsm_state); end
    send(ev(1'b0, 1'b0, 8'h75));
    n_checks++; if (cursor_moved !== 1'b0) begin n_fail++; $display("FAIL edge_plain_75_moved got %b exp 0", cursor_moved); end
    // Strobe low: other bits ignored.
    key_event = {1'b0, 1'b0, 1'b0, 8'h1C};
    tick();
    key_event = '0;
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL edge_nostrobe_state got %b exp 0", o_fsm_state); end
  endtask

  task automatic test_select();
    do_reset();
    send(ev(1'b0, 1'b0, 8'h29));
    n_checks++; if (is_pressed !== 1'b1) begin n_fail++; $display("FAIL sel_first got %b exp 1", is_pressed); end
    tick();
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL sel_width got %b exp 0", is_pressed); end
    send(ev(1'b0, 1'b0, 8'h29));
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL sel_repeat2 got %b exp 0", is_pressed); end
    send(ev(1'b0, 1'b0, 8'h29));
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL sel_repeat3 got %b exp 0", is_pressed); end
    send(ev(1'b1, 1'b0, 8'h29));
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL sel_break got %b exp 0", is_pressed); end
    send(ev(1'b0, 1'b0, 8'h29));
    n_checks++; if (is_pressed !== 1'b1) begin n_fail++; $display("FAIL sel_after_break got %b exp 1", is_pressed); end
    tick();
    n_checks++; if (is_pressed !== 1'b0) begin n_fail++; $display("FAIL sel_width2 got %b exp 0", is_pressed); end
    send(ev(1'b1, 1'b0, 8'h29));
    // Extended Enter also selects.
    send(ev(1'b0, 1'b1, 8'h5A));
    n_checks++; if (is_pressed !== 1'b1) begin n_fail++; $display("FAIL sel_enter_e0 got %b exp 1", is_pressed); end
    send(ev(1'b1, 1'b1, 8'h5A));
  endtask

  task automatic test_simultaneous();
    logic exp_m;
    logic exp_p;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(ev(1'b0, 1'b0, 8'h23));
      send(ev(1'b1, 1'b0, 8'h23));
    end
    send(ev(1'b0, 1'b0, 8'h1B));
    n_checks++; if (cursor_y !== 4'd1) begin n_fail++; $display("FAIL sim_down_y got %0d exp 1", cursor_y); end
    // At cycle 1 after Down make; counter reaches 0 on cycle 10.
    for (int i = 0; i < 9; i++) tick();
    key_event = ev(1'b0, 1'b0, 8'h1C);
    tick();
    key_event = '0;
    n_checks++; if (cursor_x !== 4'd2) begin n_fail++; $display("FAIL sim_left_x got %0d exp 2", cursor_x); end
    n_checks++; if (cursor_y !== 4'd1) begin n_fail++; $display("FAIL sim_left_y got %0d exp 1", cursor_y); end
    n_checks++; if (cursor_moved !== 1'b1) begin n_fail++; $display("FAIL sim_left_moved got %b exp 1", cursor_moved); end
    // Cycle 11: next Left repeat due at 21; a Space make at 15 must not disturb it.
    for (int c = 11; c <= 20; c++) begin
      key_event = (c == 15) ? ev(1'b0, 1'b0, 8'h29) : 11'd0;
      tick();
      exp_m = (c + 1 == 21);
      exp_p = (c + 1 == 16);
      n_checks++;
      if (cursor_moved !== exp_m) begin
        n_fail++; $display("FAIL sim_repeat cycle %0d got %b exp %b", c + 1, cursor_moved, exp_m);
      end
      n_checks++;
      if (is_pressed !== exp_p) begin
        n_fail++; $display("FAIL sim_select cycle %0d got %b exp %b", c + 1, is_pressed, exp_p);
      end
    end
    key_event = '0;
    n_checks++; if (cursor_x !== 4'd1) begin n_fail++; $display("FAIL sim_final_x got %0d exp 1", cursor_x); end
    n_checks++; if (cursor_y !== 4'd1) begin n_fail++; $display("FAIL sim_final_y got %0d exp 1", cursor_y); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(ev(1'b0, 1'b0, 8'h23));
    send(ev(1'b0, 1'b0, 8'h1B));
    n_checks++; if (cursor_y !== 4'd1) begin n_fail++; $display("FAIL b2b_y got %0d exp 1", cursor_y); end
    n_checks++; if (cursor_x !== 4'd1) begin n_fail++; $display("FAIL b2b_x got %0d exp 1", cursor_x); end
    send(ev(1'b1, 1'b0, 8'h23));
    n_checks++; if (o_fsm_state !== 1'b1) begin n_fail++; $display("FAIL b2b_nonheld_break got %b exp 1", o_fsm_state); end
    send(ev(1'b1, 1'b0, 8'h1B));
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL b2b_held_break got %b exp 0", o_fsm_state); end
  endtask

  task automatic test_reset_mid_hold();
    int moves;
    do_reset();
    send(ev(1'b0, 1'b1, 8'h74));
    for (int i = 0; i < 11; i++) tick();
    n_checks++; if (cursor_x !== 4'd2) begin n_fail++; $display("FAIL rst_pre_x got %0d exp 2", cursor_x); end
    rstn = 1'b0;
    #2;
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL rst_async_x got %0d exp 0", cursor_x); end
    n_checks++; if (o_fsm_state !== 1'b0) begin n_fail++; $display("FAIL rst_async_state got %b exp 0", o_fsm_state); end
    tick();
    tick();
    rstn  = 1'b1;
    moves = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cursor_moved) moves++;
    end
    n_checks++; if (moves !== 0) begin n_fail++; $display("FAIL rst_no_moves got %0d exp 0", moves); end
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL rst_final_x got %0d exp 0", cursor_x); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    key_event = '0;
    test_reset();
    test_make_break();
    test_hold_repeat();
    test_edges();
    test_select();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
